avl_burst_splitter: RTL and testbench

- Sits directly downstream of the cache master port (m0) and upstream of the SDRAM-side memory slave.
- Accepts Avalon-MM burst transfers from the cache (begin_burst_transfer, burst_count).
- Issues each burst as a sequence of single-word pipelined transfers to a memory that has no burst support, and returns read data in order.
- Limits outstanding reads so the memory side is never overrun.

---
 rtl/avl_burst_splitter_if.sv | 31 +++
 rtl/avl_burst_splitter.sv | 201 ++++++++++++++++++++
 tb/tb_avl_burst_splitter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avl_burst_splitter_if.sv
// Avalon-MM bus bundle used on both sides of the burst splitter.
// The cache side (s0) uses every field. The memory side (m0) leaves the
// burst fields idle because the memory has no burst support.
interface avl_burst_splitter_if #(
    parameter int BURST_W = 8
);
    logic [31:0]        address;
    logic [3:0]         byte_enable;
    logic               read;
    logic               write;
    logic [31:0]        write_data;
    logic               begin_burst_transfer;
    logic [BURST_W-1:0] burst_count;
    logic               wait_request;
    logic [31:0]        read_data;
    logic               read_data_valid;

    // Issuer of commands.
    modport master (
        output address, byte_enable, read, write, write_data,
               begin_burst_transfer, burst_count,
        input  wait_request, read_data, read_data_valid
    );

    // Receiver of commands.
    modport slave (
        input  address, byte_enable, read, write, write_data,
               begin_burst_transfer, burst_count,
        output wait_request, read_data, read_data_valid
    );
endinterface

// File: rtl/avl_burst_splitter.sv
// Avalon-MM burst splitter.
// Takes read and write bursts from the cache master and replays each one as
// single-word pipelined transfers toward a memory that cannot burst. Read data
// comes back in issue order. An outstanding-read counter throttles issue so the
// memory never holds more than MAX_PENDING reads.
module avl_burst_splitter #(
    parameter int BURST_W     = 8,
    parameter int MAX_PENDING = 4,
    parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  rest,
    avl_burst_splitter_if.slave   s0,
    avl_burst_splitter_if.master  m0
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR      = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    state_t             state_reg;
    logic [31:0]        base_reg;      // word-aligned burst start address
    logic [BURST_W-1:0] last_reg;      // index of the final beat (count 0 acts as 1)
    logic [BURST_W-1:0] beat_reg;      // index of the beat currently presented on m0
    logic               s0_wait_reg;

    logic [31:0]        m0_address_reg;
    logic [3:0]         m0_be_reg;
    logic               m0_read_reg;
    logic               m0_write_reg;
    logic [31:0]        m0_wdata_reg;

    logic [PEND_W-1:0]  pending_reg;
    logic [PEND_W-1:0]  pending_next;
    logic [31:0]        s0_rdata_reg;
    logic               s0_rvalid_reg;

    logic               rd_accept;
    logic               rd_return;
    logic               can_issue;

    // Address of a beat: base plus four bytes per beat, wrapping modulo 2^32.
    function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                              input logic [BURST_W-1:0] beat);
        return base + (32'(beat) << 2);
    endfunction

    // A read leaves on m0 when it is presented and not stalled.
    assign rd_accept = m0_read_reg && !m0.wait_request;

    // Data arriving with nothing outstanding is stale (left over from before a
    // reset) and must not reach the cache.
    assign rd_return = m0.read_data_valid && (pending_reg != '0);

    // Outstanding-read count after this edge; an issue and a return in the
    // same cycle cancel out.
    always_comb begin
        pending_next = pending_reg;
        if (rd_accept && !rd_return) begin
            pending_next = pending_reg + PEND_W'(1);
        end else if (!rd_accept && rd_return) begin
            pending_next = pending_reg - PEND_W'(1);
        end
    end

    // m0_read is registered, so the decision looks at the count it will see
    // next cycle. Once a read is presented it only stays stalled, so the
    // count cannot rise under it and the request stays steady.
    assign can_issue = (pending_next < PEND_W'(MAX_PENDING));

    // Burst sequencer with registered s0 wait and m0 command outputs.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            last_reg       <= '0;
            beat_reg       <= '0;
            s0_wait_reg    <= 1'b1;
            m0_address_reg <= '0;
            m0_be_reg      <= '0;
            m0_read_reg    <= 1'b0;
            m0_write_reg   <= 1'b0;
            m0_wdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    s0_wait_reg <= 1'b0;
                    // The first cycle after reset still shows wait high, so
                    // nothing is taken until the cache can see us ready.
                    // A read and a write together is illegal; the read wins.
                    if (!s0_wait_reg && s0.read) begin
                        base_reg       <= {s0.address[31:2], 2'b00};
                        last_reg       <= (s0.burst_count == '0) ? '0
                                          : s0.burst_count - BURST_W'(1);
                        beat_reg       <= '0;
                        m0_address_reg <= {s0.address[31:2], 2'b00};
                        m0_be_reg      <= s0.byte_enable;
                        m0_read_reg    <= can_issue;
                        s0_wait_reg    <= 1'b1;
                        state_reg      <= RD;
                    end else if (!s0_wait_reg && s0.write) begin
                        base_reg       <= {s0.address[31:2], 2'b00};
                        last_reg       <= (s0.burst_count == '0) ? '0
                                          : s0.burst_count - BURST_W'(1);
                        beat_reg       <= '0;
                        m0_address_reg <= {s0.address[31:2], 2'b00};
                        m0_be_reg      <= s0.byte_enable;
                        m0_wdata_reg   <= s0.write_data;
                        m0_write_reg   <= 1'b1;
                        s0_wait_reg    <= 1'b1;
                        state_reg      <= WR;
                    end
                end

                RD: begin
                    if (rd_accept && (beat_reg == last_reg)) begin
                        // Last address issued; remaining data drains while
                        // the next command may already be accepted.
                        m0_read_reg <= 1'b0;
                        s0_wait_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (rd_accept) begin
                        beat_reg       <= beat_reg + BURST_W'(1);
                        m0_address_reg <= beat_addr(base_reg, beat_reg + BURST_W'(1));
                        m0_read_reg    <= can_issue;
                    end else begin
                        m0_read_reg    <= can_issue;
                    end
                end

                WR: begin
                    if (!m0.wait_request) begin
                        m0_write_reg <= 1'b0;
                        s0_wait_reg  <= 1'b0;
                        if (beat_reg == last_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            beat_reg  <= beat_reg + BURST_W'(1);
                            state_reg <= WR_DATA;
                        end
                    end
                end

                WR_DATA: begin
                    // m0 idles here while the next beat is collected from s0.
                    if (s0.write) begin
                        m0_address_reg <= beat_addr(base_reg, beat_reg);
                        m0_wdata_reg   <= s0.write_data;
                        m0_be_reg      <= s0.byte_enable;
                        m0_write_reg   <= 1'b1;
                        s0_wait_reg    <= 1'b1;
                        state_reg      <= WR;
                    end
                end

                default: begin
                    m0_read_reg  <= 1'b0;
                    m0_write_reg <= 1'b0;
                    s0_wait_reg  <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    // Outstanding-read counter and one-cycle registered read return path.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            pending_reg   <= '0;
            s0_rdata_reg  <= '0;
            s0_rvalid_reg <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            s0_rvalid_reg <= rd_return;
            if (rd_return) begin
                s0_rdata_reg <= m0.read_data;
            end
        end
    end

    assign s0.wait_request         = s0_wait_reg;
    assign s0.read_data            = s0_rdata_reg;
    assign s0.read_data_valid      = s0_rvalid_reg;

    assign m0.address              = m0_address_reg;
    assign m0.byte_enable          = m0_be_reg;
    assign m0.read                 = m0_read_reg;
    assign m0.write                = m0_write_reg;
    assign m0.write_data           = m0_wdata_reg;
    assign m0.begin_burst_transfer = 1'b0;
    assign m0.burst_count          = '0;

    // Beat boundaries come from the FSM, so the burst marker and the byte
    // offset bits of the start address carry no information here.
    logic unused_ok;
    assign unused_ok = &{1'b0, s0.begin_burst_transfer, s0.address[1:0]};

endmodule

// File: tb/tb_avl_burst_splitter.sv
// Directed bench for avl_burst_splitter: a word memory model with
// programmable read latency and stall injection sits on m0, a linear
// sequence of steps drives s0, and monitors log every m0 and s0 transfer.
module tb_avl_burst_splitter;

    localparam int BURST_W     = 8;
    localparam int MAX_PENDING = 4;

    logic clk;
    logic rest;

    avl_burst_splitter_if #(.BURST_W(BURST_W)) s0_bus ();
    avl_burst_splitter_if #(.BURST_W(BURST_W)) m0_bus ();

    avl_burst_splitter #(
        .BURST_W     (BURST_W),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk  (clk),
        .rest (rest),
        .s0   (s0_bus.slave),
        .m0   (m0_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model state.
    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    logic [31:0] mem [0:1023];
    ret_t        ret_q[$];
    int          lat;
    int          cyc;
    logic        force_wait;
    logic        stray_rvalid;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    assign m0_bus.wait_request    = force_wait;
    assign m0_bus.read_data_valid = mem_rvalid | stray_rvalid;
    assign m0_bus.read_data       = stray_rvalid ? 32'hDEAD_BEEF : mem_rdata;

    // Logs.
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_be_q[$];
    logic [31:0] s0_ret_q[$];
    int          tb_out;
    int          tb_out_max;
    int          over_issue;

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: all signals are settled at the falling edge.
    initial forever begin
        @(negedge clk);
        if (m0_bus.read && (tb_out >= MAX_PENDING)) over_issue++;
        if (m0_bus.read && !m0_bus.wait_request) begin
            ret_t r;
            r.due  = cyc + lat;
            r.data = mem[m0_bus.address[11:2]];
            ret_q.push_back(r);
            rd_addr_q.push_back(m0_bus.address);
            rd_cyc_q.push_back(cyc);
            tb_out++;
        end
        if (mem_rvalid) tb_out--;
        if (tb_out > tb_out_max) tb_out_max = tb_out;
        if (m0_bus.write && !m0_bus.wait_request) begin
            for (int b = 0; b < 4; b++) begin
                if (m0_bus.byte_enable[b])
                    mem[m0_bus.address[11:2]][8*b +: 8] = m0_bus.write_data[8*b +: 8];
            end
            wr_addr_q.push_back(m0_bus.address);
            wr_data_q.push_back(m0_bus.write_data);
            wr_be_q.push_back(m0_bus.byte_enable);
        end
        if (s0_bus.read_data_valid) s0_ret_q.push_back(s0_bus.read_data);
        cyc++;
    end

    // Memory read-data driver: returns each read lat cycles after issue.
    initial forever begin
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ret_q[0].data;
            void'(ret_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_be_q.delete();
        s0_ret_q.delete();
        tb_out_max = tb_out;
        over_issue = 0;
    endtask

    // Wait for s0 to take the presented command/beat, then step past that edge.
    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        while (s0_bus.wait_request !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " accept in time"}, 32'(n < 200), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic read_cmd(input logic [31:0] addr, input logic [7:0] cnt, input logic [3:0] be);
        s0_bus.address              = addr;
        s0_bus.burst_count          = cnt;
        s0_bus.byte_enable          = be;
        s0_bus.read                 = 1'b1;
        s0_bus.begin_burst_transfer = 1'b1;
        wait_accept("read cmd");
        s0_bus.read                 = 1'b0;
        s0_bus.begin_burst_transfer = 1'b0;
        $display("read  cmd addr=%h count=%0d be=%h", addr, cnt, be);
    endtask

    task automatic write_beat(input logic [31:0] addr, input logic [7:0] cnt, input logic first,
                              input logic [31:0] data, input logic [3:0] be);
        s0_bus.address              = addr;
        s0_bus.burst_count          = cnt;
        s0_bus.byte_enable          = be;
        s0_bus.write_data           = data;
        s0_bus.write                = 1'b1;
        s0_bus.begin_burst_transfer = first;
        wait_accept("write beat");
        s0_bus.write                = 1'b0;
        s0_bus.begin_burst_transfer = 1'b0;
        $display("write beat addr=%h data=%h be=%h", addr, data, be);
    endtask

    task automatic wait_returns(input int n, input string tag);
        int k;
        k = 0;
        while (s0_ret_q.size() < n && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check({tag, " return count"}, 32'(s0_ret_q.size()), 32'(n));
    endtask

    task automatic release_reset(input string tag);
        rest = 1'b1;
        check({tag, " wait still high at release"}, 32'(s0_bus.wait_request), 32'd1);
        @(posedge clk); #1;
        check({tag, " wait low after first edge"}, 32'(s0_bus.wait_request), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s0 wait"},   32'(s0_bus.wait_request),    32'd1);
        check({tag, " s0 rvalid"}, 32'(s0_bus.read_data_valid), 32'd0);
        check({tag, " s0 rdata"},  s0_bus.read_data,            32'd0);
        check({tag, " m0 read"},   32'(m0_bus.read),            32'd0);
        check({tag, " m0 write"},  32'(m0_bus.write),           32'd0);
        check({tag, " m0 addr"},   m0_bus.address,              32'd0);
        check({tag, " m0 wdata"},  m0_bus.write_data,           32'd0);
        check({tag, " m0 be"},     32'(m0_bus.byte_enable),     32'd0);
    endtask

    logic [31:0] exp_w [0:15];
    int          n;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        lat          = 1;
        tb_out       = 0;
        tb_out_max   = 0;
        over_issue   = 0;
        force_wait   = 1'b0;
        stray_rvalid = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5EED_0000 | 32'(i);
        mem[10'h040] = 32'hA0A0_A0A0;
        mem[10'h041] = 32'hA1A1_A1A1;
        mem[10'h042] = 32'hA2A2_A2A2;
        mem[10'h043] = 32'hA3A3_A3A3;
        mem[10'h081] = 32'h5555_5555;
        mem[10'h082] = 32'h6666_6666;

        s0_bus.address              = '0;
        s0_bus.byte_enable          = '0;
        s0_bus.read                 = 1'b0;
        s0_bus.write                = 1'b0;
        s0_bus.write_data           = '0;
        s0_bus.begin_burst_transfer = 1'b0;
        s0_bus.burst_count          = '0;
        rest = 1'b0;

        // Power-on reset.
        repeat (2) begin @(posedge clk); #1; end
        check_reset_outputs("reset");
        release_reset("reset");

        // 1: four-beat read, back-to-back issue, in-order return.
        clear_logs();
        read_cmd(32'h0000_0100, 8'd4, 4'hF);
        check("t1 wait after accept", 32'(s0_bus.wait_request), 32'd1);
        n = 0;
        while (s0_bus.wait_request === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        check("t1 wait high cycles", 32'(n), 32'd4);
        wait_returns(4, "t1");
        check("t1 read count", 32'(rd_addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("t1 addr%0d", i), rd_addr_q[i], 32'h100 + 32'(4*i));
        check("t1 back-to-back span", 32'(rd_cyc_q[3] - rd_cyc_q[0]), 32'd3);
        check("t1 data0", s0_ret_q[0], 32'hA0A0_A0A0);
        check("t1 data1", s0_ret_q[1], 32'hA1A1_A1A1);
        check("t1 data2", s0_ret_q[2], 32'hA2A2_A2A2);
        check("t1 data3", s0_ret_q[3], 32'hA3A3_A3A3);

        // 2: three-beat write with mixed byte enables, then readback.
        clear_logs();
        write_beat(32'h0000_0200, 8'd3, 1'b1, 32'h1111_1111, 4'hF);
        write_beat(32'h0000_0200, 8'd3, 1'b0, 32'h2222_2222, 4'h3);
        write_beat(32'h0000_0200, 8'd3, 1'b0, 32'h3333_3333, 4'hC);
        repeat (4) begin @(posedge clk); #1; end
        check("t2 write count", 32'(wr_addr_q.size()), 32'd3);
        check("t2 addr0", wr_addr_q[0], 32'h0000_0200);
        check("t2 addr1", wr_addr_q[1], 32'h0000_0204);
        check("t2 addr2", wr_addr_q[2], 32'h0000_0208);
        check("t2 data0", wr_data_q[0], 32'h1111_1111);
        check("t2 data1", wr_data_q[1], 32'h2222_2222);
        check("t2 data2", wr_data_q[2], 32'h3333_3333);
        check("t2 be0", 32'(wr_be_q[0]), 32'hF);
        check("t2 be1", 32'(wr_be_q[1]), 32'h3);
        check("t2 be2", 32'(wr_be_q[2]), 32'hC);
        clear_logs();
        read_cmd(32'h0000_0200, 8'd3, 4'hF);
        wait_returns(3, "t2 readback");
        check("t2 rb0", s0_ret_q[0], 32'h1111_1111);
        check("t2 rb1", s0_ret_q[1], 32'h5555_2222);
        check("t2 rb2", s0_ret_q[2], 32'h3333_6666);

        // 3: eight-beat read with a 5-cycle stall on beat 2.
        clear_logs();
        read_cmd(32'h0000_0100, 8'd8, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        force_wait = 1'b1;
        check("t3 read held in stall", 32'(m0_bus.read), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3 stall addr c%0d", i), m0_bus.address, 32'h0000_0108);
            @(posedge clk); #1;
        end
        force_wait = 1'b0;
        wait_returns(8, "t3");
        check("t3 read count", 32'(rd_addr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("t3 addr%0d", i), rd_addr_q[i], 32'h100 + 32'(4*i));
        exp_w[0] = 32'hA0A0_A0A0;
        exp_w[1] = 32'hA1A1_A1A1;
        exp_w[2] = 32'hA2A2_A2A2;
        exp_w[3] = 32'hA3A3_A3A3;
        for (int i = 4; i < 16; i++) exp_w[i] = 32'h5EED_0040 + 32'(i);
        for (int i = 0; i < 8; i++) check($sformatf("t3 data%0d", i), s0_ret_q[i], exp_w[i]);

        // 4: sixteen-beat read against an 8-cycle memory; pending limit 4.
        clear_logs();
        lat = 8;
        read_cmd(32'h0000_0100, 8'd16, 4'hF);
        wait_returns(16, "t4");
        lat = 1;
        check("t4 issue with limit reached", 32'(over_issue), 32'd0);
        check("t4 max outstanding", 32'(tb_out_max), 32'd4);
        check("t4 read count", 32'(rd_addr_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) check($sformatf("t4 data%0d", i), s0_ret_q[i], exp_w[i]);

        // 5: address wrap at the top of the 32-bit space.
        clear_logs();
        read_cmd(32'hFFFF_FFFC, 8'd2, 4'hF);
        wait_returns(2, "t5");
        check("t5 addr0", rd_addr_q[0], 32'hFFFF_FFFC);
        check("t5 addr1", rd_addr_q[1], 32'h0000_0000);
        check("t5 data0", s0_ret_q[0], 32'h5EED_03FF);
        check("t5 data1", s0_ret_q[1], 32'h5EED_0000);

        // 6: reset in the middle of a four-beat write, then a stray return.
        clear_logs();
        write_beat(32'h0000_0300, 8'd4, 1'b1, 32'hBEEF_0001, 4'hF);
        @(posedge clk); #1;
        s0_bus.write      = 1'b1;
        s0_bus.write_data = 32'hBEEF_0002;
        rest = 1'b0;
        #1;
        check_reset_outputs("t6 in reset");
        repeat (2) begin @(posedge clk); #1; end
        check("t6 wait held in reset", 32'(s0_bus.wait_request), 32'd1);
        s0_bus.write = 1'b0;
        release_reset("t6");
        repeat (4) begin @(posedge clk); #1; end
        check("t6 write count", 32'(wr_addr_q.size()), 32'd1);
        check("t6 write addr", wr_addr_q[0], 32'h0000_0300);
        check("t6 write data", wr_data_q[0], 32'hBEEF_0001);
        stray_rvalid = 1'b1;
        @(posedge clk); #1;
        stray_rvalid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("t6 stray dropped", 32'(s0_ret_q.size()), 32'd0);
        $display("stray rvalid injected, s0 returns=%0d", s0_ret_q.size());

        // Count 0 behaves as a single beat.
        clear_logs();
        read_cmd(32'h0000_0040, 8'd0, 4'hF);
        wait_returns(1, "t6 count0");
        check("t6 count0 reads", 32'(rd_addr_q.size()), 32'd1);
        check("t6 count0 addr", rd_addr_q[0], 32'h0000_0040);
        check("t6 count0 data", s0_ret_q[0], 32'h5EED_0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
